// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared constants, checker state type and feedback function for the
// 16-bit Fibonacci LFSR (taps 0,2,3,5 of a right-shifting register).
package lfsr_pkg;
    localparam int LFSR_W = 16;
    localparam logic [LFSR_W-1:0] TAP_MASK = 16'h002D;
    localparam logic [LFSR_W-1:0] SEED_VALUE = 16'hECEB;

    typedef enum logic [1:0] {FILL, VERIFY, LOCKED} chk_state_t;

    function automatic logic lfsr_fb(input logic [LFSR_W-1:0] s);
        return ^(s & TAP_MASK);
    endfunction
endpackage

// File: rtl/lfsr_checker_sat_counter.sv
// sat_counter: W-bit up-counter that sticks at all-ones; clr wins over inc.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] value
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) value <= '0;
        else        value <= clr ? '0 : value + W'(inc && !(&value));
endmodule

// File: rtl/lfsr_checker.sv
// lfsr_checker: self-synchronising checker for the 16-bit LFSR stream; fills a
// window from the line, verifies predictions, then flywheels and counts bit errors.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int LOCK_GOOD   = 16,
    parameter int LOSS_THRESH = 4,
    parameter int ERR_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              rand_bit,
    input  logic              clr_err,
    output logic              locked,
    output logic              err_pulse,
    output logic [ERR_W-1:0]  err_count,
    output logic [LFSR_W-1:0] state_est
);
    localparam logic [15:0] GOOD_LAST = 16'(LOCK_GOOD - 1);
    localparam logic [7:0]  BAD_LAST  = 8'(LOSS_THRESH - 1);

    chk_state_t        state;
    logic [LFSR_W-1:0] win;
    logic [3:0]        fill_cnt;
    logic [15:0]       good_cnt;
    logic [7:0]        bad_cnt;
    logic              pred, mis, err_inc, win_zero;

    assign pred      = lfsr_fb(win);
    assign mis       = rand_bit != pred;
    assign win_zero  = win == '0;
    assign err_inc   = en && state == LOCKED && mis;
    assign state_est = win;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            win       <= '0;
            fill_cnt  <= '0;
            good_cnt  <= '0;
            bad_cnt   <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= err_inc;
            if (en) begin
                // once locked the window runs on its own predictions so line errors never pollute it
                win <= {state == LOCKED ? pred : rand_bit, win[LFSR_W-1:1]};
                case (state)
                    FILL: begin
                        fill_cnt <= fill_cnt + 4'd1;
                        if (fill_cnt == 4'd15) begin
                            state    <= VERIFY;
                            good_cnt <= '0;
                        end
                    end
                    VERIFY: begin
                        good_cnt <= (mis || win_zero) ? '0 : good_cnt + 16'd1;
                        if (!mis && !win_zero && good_cnt == GOOD_LAST) begin
                            state   <= LOCKED;
                            locked  <= 1'b1;
                            bad_cnt <= '0;
                        end
                    end
                    default: begin
                        bad_cnt <= mis ? bad_cnt + 8'd1 : '0;
                        if (mis && bad_cnt == BAD_LAST) begin
                            state    <= FILL;
                            locked   <= 1'b0;
                            fill_cnt <= '0;
                        end
                    end
                endcase
            end
        end
    end

    sat_counter #(.W(ERR_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (err_inc),
        .clr   (clr_err),
        .value (err_count)
    );
endmodule

// File: doc/lfsr_checker.md
Name: lfsr_checker

Overview:
- Receive-side companion to the 16-bit Fibonacci LFSR generator.
- Consumes the generator's serial `rand_bit` stream, one bit per `en` strobe, and self-synchronises to the sequence.
- Flags and counts bit errors after lock.
- Used in the same verification environment to check a generator over a link, or as an in-fabric BIST checker.

Parameters:
- LOCK_GOOD, 16: consecutive correct predictions needed after window fill to declare lock (1..65535).
- LOSS_THRESH, 4: consecutive mismatches while locked that drop lock (1..255).
- ERR_W, 16: width of error counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  input bit valid strobe; may be held or gapped arbitrarily.
- rand_bit  in  1  received serial bit, sampled when en=1.
- clr_err  in  1  synchronous clear of err_count.
- locked  out  1  checker synchronised to sequence.
- err_pulse  out  1  one-cycle pulse: bit sampled on previous edge mismatched while locked.
- err_count  out  ERR_W  saturating mismatch count since reset/clr_err.
- state_est  out  16  current 16-bit window (estimated generator state).

Behaviour:
- Polynomial, fixed: generator emits state[0], then shifts right inserting state[0]^state[2]^state[3]^state[5] at bit 15.
- Window reg `win[15:0]`: oldest bit in win[0].
- Predicted next bit: `pred = win[0]^win[2]^win[3]^win[5]`, combinational.
- On every en=1 edge, win <= {nb, win[15:1]}.
  - SEARCH/VERIFY: nb = rand_bit.
  - LOCKED: nb = pred (flywheel); a single bad bit corrupts no later predictions.
- After 16 accepted bits, win equals the generator's state at the first of those bits.
- Reset (async, rst_n=0): state=FILL, win=0, fill_cnt=0, good_cnt=0, bad_cnt=0, locked=0, err_pulse=0, err_count=0, state_est=0.
- FILL:
  - Each en increments fill_cnt.
  - When the 16th bit is accepted, go to VERIFY with good_cnt=0.
- VERIFY:
  - On en, if rand_bit==pred, good_cnt++; else good_cnt=0.
  - If win is all-zero, hold good_cnt=0 (lock-up state is never valid).
  - When the LOCK_GOOD-th consecutive match is accepted, go to LOCKED; locked=1 from the next cycle.
- LOCKED:
  - On en, if rand_bit!=pred: err_pulse=1 next cycle, err_count++ (saturate at all-ones), bad_cnt++.
  - On a match, bad_cnt=0.
  - When the LOSS_THRESH-th consecutive mismatch is accepted: go to FILL, locked=0 next cycle, fill_cnt=0.
  - The mismatch that causes loss still counts and pulses.
- en=0: no state, window or counter change; err_pulse=0.
- clr_err=1: err_count=0 that edge. It has priority over a simultaneous increment, but err_pulse still fires.
- err_count does not increment outside LOCKED.
- Latency: the error on the bit accepted at edge N shows as err_pulse/err_count at edge N (visible after it).
- Minimum lock time from reset: 16+LOCK_GOOD accepted bits.
- rst_n deassertion mid-stream: restarts from FILL, no stale lock.

Decomposition:
- Package `lfsr_pkg`:
  - `LFSR_W=16`
  - tap mask constant `16'h002D`
  - `SEED_VALUE=16'hECEB`
  - enum `chk_state_t {FILL, VERIFY, LOCKED}`
  - function `lfsr_fb(logic [15:0])` returning the feedback bit, shared with generator and benches.
- One natural sub-module: `sat_counter` (parameter W; inc, clr, value; saturates), used for err_count.

Test Plan:
- Reset, then feed the generator stream from seed 0xECEB (first bits 1,1,0,1,0,1,1,1,0,0,1,1,0,1,1,1) with LOCK_GOOD=16 → state_est=0xECEB after 16th bit; locked rises after the 32nd accepted bit; err_count=0.
- Locked, flip bit #100 only → one err_pulse, err_count=1; locked stays 1; subsequent bits produce no further errors (flywheel).
- Locked, flip 4 consecutive bits (LOSS_THRESH=4) → err_count=4; locked=0 after the 4th; clean stream → relock after 16+16 further bits.
- Feed all-zero bits for 200 strobes → never locked; err_count=0.
- Random en gaps of 0-3 cycles across the full 65535-bit period → locked held throughout; err_count=0; state_est returns to 0xECEB after each period.
- Assert rst_n low mid-LOCKED with err_count=3; also pulse clr_err coincident with a mismatch → immediate zero of all outputs; after the clear, err_count=0 while err_pulse=1.
